// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_ctrl_pkg
// Purpose  : Shared constants and types for the LED matrix UART command
//            front-end: command byte values, line length and the state
//            encodings of the command decoder and the byte receiver.
// Ports    : none (package)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

  // Command bytes recognised while the decoder is idle
  localparam logic [7:0] CMD_BRIGHTNESS = 8'h62;  // 'b'
  localparam logic [7:0] CMD_RGB        = 8'h52;  // 'R'
  localparam logic [7:0] CMD_LINE       = 8'h4C;  // 'L'

  // Bytes per display line loaded by a line command
  localparam int LINE_BYTES = 128;

  // Command decoder state, exported on cmd_line_state2
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARG  = 2'd1,
    ROW  = 2'd2,
    DATA = 2'd3
  } cmd_state_e;

  // Which enable register the pending argument byte is written to
  typedef enum logic {
    TGT_BRIGHTNESS = 1'b0,
    TGT_RGB        = 1'b1
  } arg_target_e;

  // Serial byte receiver state
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_BITS  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_rx
// Purpose  : 8N1 serial byte receiver. Synchronises the line, detects the
//            start edge, validates the start bit at mid-bit, samples eight
//            data bits LSB first at mid-bit and checks the stop bit.
// Ports    : clk_in       - system clock
//            reset        - synchronous active-high reset
//            uart_rx_i    - serial input, idle high
//            byte_o       - last received byte
//            byte_valid_o - one-cycle pulse when byte_o holds a good byte
//            rx_running_o - high while a frame is being received
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_rx
  import led_ctrl_pkg::*;
#(
  parameter int UART_CLK_DIV_COUNT = 25,
  parameter int UART_CLK_DIV_WIDTH = 8
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       uart_rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       rx_running_o
);

  // Terminal counts: half a bit to reach mid start bit, a full bit thereafter
  localparam logic [UART_CLK_DIV_WIDTH-1:0] HALF_LAST =
    UART_CLK_DIV_WIDTH'(UART_CLK_DIV_COUNT - 1);
  localparam logic [UART_CLK_DIV_WIDTH-1:0] FULL_LAST =
    UART_CLK_DIV_WIDTH'(2 * UART_CLK_DIV_COUNT - 1);

  logic [1:0]                    sync_q;
  logic                          prev_q;
  rx_state_e                     state_q, state_d;
  logic [UART_CLK_DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]                    bit_q, bit_d;
  logic [7:0]                    shift_q, shift_d;
  logic                          valid_q, valid_d;
  logic                          running_q, running_d;

  logic rx_s;
  logic fall;

  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;

  // Synchroniser and edge-detect history; preset to the idle-high level so
  // leaving reset never looks like a start edge.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], uart_rx_i};
      prev_q <= rx_s;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    running_d = running_q;
    valid_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d   = RX_START;
          cnt_d     = '0;
          running_d = 1'b1;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = 3'd0;
          if (rx_s) begin
            // Line went back high: glitch, not a start bit
            state_d   = RX_IDLE;
            running_d = 1'b0;
          end else begin
            state_d = RX_BITS;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BITS: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          state_d   = RX_IDLE;
          running_d = 1'b0;
          // A low stop bit is a framing error; the byte is dropped silently
          valid_d   = rx_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      running_q <= running_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign rx_running_o = running_q;

endmodule
`default_nettype wire

// File: rtl/led_ctrl_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : led_ctrl_cmd_rx
// Purpose  : UART command front-end for the LED matrix. Decodes 'b' (set
//            brightness-bit enable), 'R' (set colour-plane enable) and 'L'
//            (load one 128-byte display line into the frame RAM).
// Ports    : clk_in, reset        - clock, synchronous active-high reset
//            uart_rx              - serial input, idle high
//            rx_running           - frame reception in progress
//            rgb_enable[2:0]      - colour-plane enable
//            brightness_enable[5:0] - brightness-bit enable
//            ram_data_out[7:0], ram_address[11:0], ram_write_enable,
//            ram_clk_enable, ram_reset - frame RAM write port
//            cmd_line_state2[1:0] - command decoder state
// Options  : CTRL_RX_TIMEOUT_EN - when defined, a command left incomplete
//            for 32 bit periods is abandoned and the decoder returns idle.
// Revision : 1.0 - initial release
// ============================================================================
module led_ctrl_cmd_rx
  import led_ctrl_pkg::*;
#(
  parameter int UART_CLK_DIV_COUNT = 25,
  parameter int UART_CLK_DIV_WIDTH = 8
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        rx_running,
  output logic [2:0]  rgb_enable,
  output logic [5:0]  brightness_enable,
  output logic [7:0]  ram_data_out,
  output logic [11:0] ram_address,
  output logic        ram_write_enable,
  output logic        ram_clk_enable,
  output logic        ram_reset,
  output logic [1:0]  cmd_line_state2
);

  logic [7:0] rx_byte;
  logic       rx_valid;

  uart_byte_rx #(
    .UART_CLK_DIV_COUNT(UART_CLK_DIV_COUNT),
    .UART_CLK_DIV_WIDTH(UART_CLK_DIV_WIDTH)
  ) u_rx (
    .clk_in      (clk_in),
    .reset       (reset),
    .uart_rx_i   (uart_rx),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .rx_running_o(rx_running)
  );

  cmd_state_e  state_q, state_d;
  arg_target_e target_q, target_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [2:0]  rgb_q, rgb_d;
  logic [5:0]  bri_q, bri_d;
  logic [7:0]  data_q, data_d;
  logic [11:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        ram_reset_q;
  logic        timeout_hit;

`ifdef CTRL_RX_TIMEOUT_EN
  localparam int TO_CYCLES = 64 * UART_CLK_DIV_COUNT;
  localparam int TO_W      = $clog2(TO_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;

  // Counts cycles spent waiting inside a command; any byte restarts it
  always_ff @(posedge clk_in) begin
    if (reset || state_q == IDLE || rx_valid) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (to_cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    row_d    = row_q;
    col_d    = col_q;
    rgb_d    = rgb_q;
    bri_d    = bri_q;
    data_d   = data_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          case (rx_byte)
            CMD_BRIGHTNESS: begin
              state_d  = ARG;
              target_d = TGT_BRIGHTNESS;
            end
            CMD_RGB: begin
              state_d  = ARG;
              target_d = TGT_RGB;
            end
            CMD_LINE: state_d = ROW;
            default:  state_d = IDLE;
          endcase
        end
        ARG: begin
          if (target_q == TGT_BRIGHTNESS) begin
            bri_d = rx_byte[5:0];
          end else begin
            rgb_d = rx_byte[2:0];
          end
          state_d = IDLE;
        end
        ROW: begin
          row_d   = rx_byte[4:0];
          col_d   = 7'd0;
          state_d = DATA;
        end
        DATA: begin
          data_d = rx_byte;
          addr_d = {row_q, col_q};
          we_d   = 1'b1;
          col_d  = col_q + 1'b1;
          if (col_q == 7'(LINE_BYTES - 1)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= TGT_BRIGHTNESS;
      row_q    <= 5'd0;
      col_q    <= 7'd0;
      rgb_q    <= 3'b111;
      bri_q    <= 6'b111111;
      data_q   <= 8'h00;
      addr_q   <= 12'h000;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      row_q    <= row_d;
      col_q    <= col_d;
      rgb_q    <= rgb_d;
      bri_q    <= bri_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
    end
  end

  // RAM reset is simply reset delayed by one cycle
  always_ff @(posedge clk_in) begin
    ram_reset_q <= reset;
  end

  assign rgb_enable        = rgb_q;
  assign brightness_enable = bri_q;
  assign ram_data_out      = data_q;
  assign ram_address       = addr_q;
  assign ram_write_enable  = we_q;
  assign ram_clk_enable    = (state_q == DATA) | we_q;
  assign ram_reset         = ram_reset_q;
  assign cmd_line_state2   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_led_ctrl_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_ctrl_cmd_rx
// Purpose  : Self-checking bench for led_ctrl_cmd_rx. Serial frames are
//            driven at 50 clocks per bit; a byte-level model of the command
//            set predicts enables, decoder state and the RAM write stream.
// Options  : CTRL_RX_TIMEOUT_EN - enables the command timeout checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_ctrl_cmd_rx;

  localparam int BIT = 50;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rx = 1'b1;
  logic        rx_running;
  logic [2:0]  rgb_enable;
  logic [5:0]  brightness_enable;
  logic [7:0]  ram_data_out;
  logic [11:0] ram_address;
  logic        ram_write_enable;
  logic        ram_clk_enable;
  logic        ram_reset;
  logic [1:0]  cmd_line_state2;

  led_ctrl_cmd_rx #(
    .UART_CLK_DIV_COUNT(25),
    .UART_CLK_DIV_WIDTH(8)
  ) dut (
    .clk_in           (clk),
    .reset            (reset),
    .uart_rx          (uart_rx),
    .rx_running       (rx_running),
    .rgb_enable       (rgb_enable),
    .brightness_enable(brightness_enable),
    .ram_data_out     (ram_data_out),
    .ram_address      (ram_address),
    .ram_write_enable (ram_write_enable),
    .ram_clk_enable   (ram_clk_enable),
    .ram_reset        (ram_reset),
    .cmd_line_state2  (cmd_line_state2)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_writes = 0;

  // Byte-level model of the command set
  int         m_phase;     // 0 waiting command, 1 argument, 2 row, 3 line data
  bit         m_to_bri;
  logic [4:0] m_row;
  int         m_col;
  logic [5:0] m_bri;
  logic [2:0] m_rgb;
  logic [19:0] exp_q[$];   // {address, data} of expected RAM writes

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_to_bri = 1'b0;
    m_row    = 5'd0;
    m_col    = 0;
    m_bri    = 6'h3F;
    m_rgb    = 3'h7;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (m_phase)
      0: begin
        if (b == 8'h62) begin m_phase = 1; m_to_bri = 1'b1; end
        else if (b == 8'h52) begin m_phase = 1; m_to_bri = 1'b0; end
        else if (b == 8'h4C) m_phase = 2;
      end
      1: begin
        if (m_to_bri) m_bri = b[5:0];
        else          m_rgb = b[2:0];
        m_phase = 0;
      end
      2: begin
        m_row   = b[4:0];
        m_col   = 0;
        m_phase = 3;
      end
      default: begin
        exp_q.push_back({m_row, 7'(m_col), b});
        m_col++;
        if (m_col == 128) m_phase = 0;
      end
    endcase
  endtask

  task automatic check_regs(input string tag);
    check({tag, "/state"}, 32'(cmd_line_state2), 32'(m_phase));
    check({tag, "/bri"}, 32'(brightness_enable), 32'(m_bri));
    check({tag, "/rgb"}, 32'(rgb_enable), 32'(m_rgb));
  endtask

  // Drive one 8N1 frame; the model sees the byte first so expected writes
  // are queued before the DUT can produce them.
  task automatic send_byte(input logic [7:0] b, input logic stop, input bit chk_run);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    if (stop) model_byte(b);
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      for (int c = 0; c < BIT; c++) begin
        @(negedge clk);
        if (chk_run && i == 3 && c == 0) check("rx_running_mid", 32'(rx_running), 32'd1);
      end
    end
    uart_rx = 1'b1;
    repeat (GAP) @(negedge clk);
    if (chk_run) check("rx_running_end", 32'(rx_running), 32'd0);
  endtask

  // RAM write monitor
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (!reset && ram_write_enable) begin
      logic [19:0] e;
      n_writes++;
      check("we_single_cycle", 32'(prev_we), 32'd0);
      check("clk_en_on_write", 32'(ram_clk_enable), 32'd1);
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_address), 32'(e[19:8]));
        check("wr_data", 32'(ram_data_out), 32'(e[7:0]));
      end
    end
    prev_we = ram_write_enable;
  end

  initial begin
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int w0;
    model_reset();

    // Reset state and the delayed RAM reset
    repeat (4) @(negedge clk);
    check("rst_ram_reset", 32'(ram_reset), 32'd1);
    check("rst_we", 32'(ram_write_enable), 32'd0);
    check("rst_addr", 32'(ram_address), 32'd0);
    check("rst_data", 32'(ram_data_out), 32'd0);
    check("rst_clk_en", 32'(ram_clk_enable), 32'd0);
    check("rst_rx_running", 32'(rx_running), 32'd0);
    check_regs("rst");
    reset = 1'b0;
    check("ram_reset_delay", 32'(ram_reset), 32'd1);
    @(negedge clk);
    check("ram_reset_release", 32'(ram_reset), 32'd0);
    repeat (20) @(negedge clk);
    check_regs("idle");
    check("idle_writes", 32'(n_writes), 32'd0);

    // Brightness and RGB commands
    send_byte(8'h62, 1'b1, 1'b1);
    check_regs("b_cmd");
    send_byte(8'h72, 1'b1, 1'b1);
    check_regs("b_arg");
    send_byte(8'h52, 1'b1, 1'b0);
    send_byte(8'h20, 1'b1, 1'b0);
    check_regs("rgb_0");
    send_byte(8'h52, 1'b1, 1'b0);
    send_byte(8'h07, 1'b1, 1'b0);
    check_regs("rgb_7");

    // Start-bit glitch and framing error while an argument is pending
    send_byte(8'h62, 1'b1, 1'b0);
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_running", 32'(rx_running), 32'd1);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_abort", 32'(rx_running), 32'd0);
    check_regs("glitch");
    send_byte(8'h05, 1'b0, 1'b0);
    check_regs("framing");
    r = 8'($urandom);
    send_byte(r, 1'b1, 1'b0);
    check_regs("rand_bri");
    send_byte(8'h52, 1'b1, 1'b0);
    r = 8'($urandom);
    send_byte(r, 1'b1, 1'b0);
    check_regs("rand_rgb");

    // Full line load, row 0x2D -> addresses 0x680..0x6FF
    w0 = n_writes;
    send_byte(8'h4C, 1'b1, 1'b0);
    check_regs("line_cmd");
    send_byte(8'h2D, 1'b1, 1'b0);
    check_regs("line_row");
    for (int i = 0; i < 128; i++) begin
      r = (i == 0) ? 8'h30 : 8'($urandom);
      send_byte(r, 1'b1, 1'b0);
      if (i == 64) check_regs("line_mid");
    end
    check_regs("line_done");
    check("line_writes", 32'(n_writes - w0), 32'd128);
    check("line_queue_empty", 32'(exp_q.size()), 32'd0);

    // Partial line, then the line goes quiet
    w0 = n_writes;
    send_byte(8'h4C, 1'b1, 1'b0);
    send_byte(8'h2D, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    check("partial_writes", 32'(n_writes - w0), 32'd10);
    repeat (1700) @(negedge clk);
`ifdef CTRL_RX_TIMEOUT_EN
    m_phase = 0;
    check_regs("timeout");
    check("timeout_no_write", 32'(n_writes - w0), 32'd10);
    send_byte(8'h62, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    check_regs("after_timeout");
`else
    check_regs("no_timeout");
`endif

    // Reset in the middle of a frame wins over everything
    uart_rx = 1'b0;
    repeat (150) @(negedge clk);
    check("midframe_running", 32'(rx_running), 32'd1);
    reset = 1'b1;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("midframe_rst_running", 32'(rx_running), 32'd0);
    check("midframe_rst_we", 32'(ram_write_enable), 32'd0);
    check("midframe_rst_addr", 32'(ram_address), 32'd0);
    check_regs("midframe_rst");
    repeat (5) @(negedge clk);
    send_byte(8'h52, 1'b1, 1'b1);
    send_byte(8'h03, 1'b1, 1'b1);
    check_regs("recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_ctrl_cmd_rx.md
Name: led_ctrl_cmd_rx

Overview:
UART command front-end for the LED matrix display. It receives 8N1 serial bytes on uart_rx and decodes a small command set. Commands set the RGB-plane enable, set the brightness-bit enable, and load 128-byte display lines into the frame RAM through a simple write port. It sits between the host serial link and the frame buffer and scan logic.

Parameters:
- UART_CLK_DIV_COUNT, 25, half bit period in clk_in cycles; one bit lasts 2*UART_CLK_DIV_COUNT cycles.
- UART_CLK_DIV_WIDTH, 8, width of the bit-timing counter; must hold 2*UART_CLK_DIV_COUNT.

Ports:
- clk_in  in  1  system clock (single clock domain).
- reset  in  1  synchronous, active-high reset.
- uart_rx  in  1  serial input, idle high.
- rx_running  out  1  high while a frame is being received.
- rgb_enable  out  3  colour-plane enable.
- brightness_enable  out  6  brightness-bit enable.
- ram_data_out  out  8  write data to frame RAM.
- ram_address  out  12  frame RAM address.
- ram_write_enable  out  1  one-cycle write strobe.
- ram_clk_enable  out  1  RAM clock enable.
- ram_reset  out  1  RAM reset.
- cmd_line_state2  out  2  command FSM state.

Behaviour:
- Reset, synchronous to clk_in and active-high, forces these values:
  - rgb_enable=3'b111, brightness_enable=6'b111111.
  - ram_data_out=0, ram_address=0, ram_write_enable=0, ram_clk_enable=0.
  - rx_running=0, FSM=IDLE.
  - ram_reset is a registered copy of reset (1 cycle delayed).
  - Reset wins over every other event, including reset asserted mid-frame or mid-line.
- UART receiver:
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge while idle starts a frame and sets rx_running=1.
  - After UART_CLK_DIV_COUNT cycles the start bit is re-sampled; if it is high, this is a false start: abort and clear rx_running.
  - 8 data bits are sampled LSB first, one every 2*UART_CLK_DIV_COUNT cycles, each at mid-bit.
  - The stop bit is then sampled. If high, byte_valid pulses for 1 cycle. If low (framing error), the byte is discarded.
  - rx_running clears in the cycle the stop bit is sampled.
- Command FSM (state shown on cmd_line_state2):
  - IDLE=0:
    - 'b' (0x62) -> ARG=1, target brightness.
    - 'R' (0x52) -> ARG=1, target rgb.
    - 'L' (0x4C) -> ROW=2.
    - Any other byte is ignored and the FSM stays in IDLE.
  - ARG=1: next byte b applied the cycle after byte_valid -> IDLE.
    - brightness target: brightness_enable<=b[5:0].
    - rgb target: rgb_enable<=b[2:0].
  - ROW=2: next byte b: row<=b[4:0], col<=0 -> DATA=3.
  - DATA=3: each byte:
    - ram_data_out<=byte, ram_address<={row,col[6:0]}, ram_write_enable=1 for exactly 1 cycle, col++.
    - After the 128th byte (col==127) -> IDLE.
  - ram_clk_enable=1 whenever the FSM is in DATA or a write strobe is pending.
  - Write latency: strobe is asserted 1 cycle after byte_valid.
- Command bytes are not special in ARG/ROW/DATA; they are treated as data there.

Optional Feature:
- Macro CTRL_RX_TIMEOUT_EN.
- Defined:
  - A counter counts clk_in cycles while the FSM is not IDLE and no byte arrives.
  - Reaching 32 bit periods (64*UART_CLK_DIV_COUNT cycles) forces IDLE; no write occurs and the enables are unchanged.
  - The counter clears on each byte_valid.
- Not defined: the FSM waits indefinitely for the next byte.

Decomposition:
- Package led_ctrl_pkg holds:
  - command constants CMD_BRIGHTNESS=8'h62, CMD_RGB=8'h52, CMD_LINE=8'h4C;
  - the FSM state typedef (IDLE/ARG/ROW/DATA, 2-bit);
  - LINE_BYTES=128.
- One sub-module, uart_byte_rx: synchronizer, bit timing and shift register; outputs byte, byte_valid, rx_running.

Test Plan:
- Reset then idle line -> rgb_enable=3'b111, brightness_enable=6'h3F, cmd_line_state2=0, no writes; ram_reset follows reset delayed by 1 cycle.
- Send 'b' then 'r' (0x72) at bit period 50 cycles -> brightness_enable=6'h32, state returns to 0.
- Send 'R' then ' ' (0x20) -> rgb_enable=3'b000; then 'R',0x07 -> 3'b111.
- Send 'L', '-' (0x2D), then 128 bytes "0111..6677":
  - 128 write strobes at addresses 0x680..0x6FF, first data 0x30;
  - state 2->3->0.
- Start-bit glitch shorter than 25 cycles -> rx_running drops, no byte. Frame with stop bit 0 -> byte discarded, state unchanged.
- With CTRL_RX_TIMEOUT_EN: send 'L', '-', then 10 bytes and stop; after 1600 idle cycles -> state 0. Next 'b',0x01 -> brightness_enable=6'h01.
